// File: rtl/fpaddsub_iter.sv
// Iterative IEEE-754 single-precision adder/subtractor with a start/done handshake.
// Alignment and normalisation advance one bit per clock. Rounding is truncation.
module fpaddsub_iter #(
  parameter int unsigned MAX_ALIGN = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned DW = $clog2(MAX_ALIGN + 1);

  typedef enum logic [2:0] {StIdle, StUnpack, StAlign, StAdd, StNorm, StPack} state_e;

  state_e         state_q;
  logic [31:0]    a_q, b_q;
  logic           sx_q, eff_sub_q, nan_q, zero_q;
  logic [8:0]     ex_q;
  logic [23:0]    mx_q, my_q;
  logic [24:0]    sum_q;
  logic [DW-1:0]  d_q;

  logic [7:0]     ea, eb, big_e, small_e, diff;
  logic [23:0]    ma, mb, big_m, small_m;
  logic           a_big, big_s, is_nan;
  logic [DW-1:0]  d_init;
  logic [24:0]    sum_c, shl;
  logic [8:0]     ex_dec;
  logic [31:0]    packed_res;

  always_comb begin
    ea      = a_q[30:23];
    eb      = b_q[30:23];
    // Zero exponent covers both true zeros and denormals, which are flushed.
    ma      = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
    mb      = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
    is_nan  = (ea == 8'hFF) || (eb == 8'hFF);
    a_big   = {ea, ma} >= {eb, mb};
    big_e   = a_big ? ea : eb;
    small_e = a_big ? eb : ea;
    big_m   = a_big ? ma : mb;
    small_m = a_big ? mb : ma;
    big_s   = a_big ? a_q[31] : b_q[31];
    diff    = big_e - small_e;
    d_init  = ({24'd0, diff} >= MAX_ALIGN) ? DW'(MAX_ALIGN) : DW'(diff);
    sum_c   = eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
    shl     = {sum_q[23:0], 1'b0};
    ex_dec  = ex_q - 9'd1;
    if (nan_q) begin
      packed_res = 32'h7FC0_0000;
    end else if (zero_q) begin
      packed_res = 32'h0000_0000;
    end else if (ex_q >= 9'd255) begin
      packed_res = {sx_q, 8'hFF, 23'h0};
    end else begin
      packed_res = {sx_q, ex_q[7:0], sum_q[22:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 32'h0000_0000;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      sx_q      <= 1'b0;
      eff_sub_q <= 1'b0;
      nan_q     <= 1'b0;
      zero_q    <= 1'b0;
      ex_q      <= 9'd0;
      mx_q      <= 24'd0;
      my_q      <= 24'd0;
      sum_q     <= 25'd0;
      d_q       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= {b_in[31] ^ op, b_in[30:0]};
            nan_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy    <= 1'b1;
            state_q <= StUnpack;
          end
        end
        StUnpack: begin
          sx_q      <= big_s;
          eff_sub_q <= a_q[31] ^ b_q[31];
          ex_q      <= {1'b0, big_e};
          mx_q      <= big_m;
          my_q      <= small_m;
          d_q       <= d_init;
          if (is_nan) begin
            nan_q   <= 1'b1;
            state_q <= StPack;
          end else if (d_init != '0) begin
            state_q <= StAlign;
          end else begin
            state_q <= StAdd;
          end
        end
        StAlign: begin
          my_q <= my_q >> 1;
          d_q  <= d_q - DW'(1);
          if (d_q == DW'(1)) state_q <= StAdd;
        end
        StAdd: begin
          sum_q <= sum_c;
          if (sum_c == 25'd0) begin
            zero_q  <= 1'b1;
            state_q <= StPack;
          end else if (sum_c[24] || !sum_c[23]) begin
            state_q <= StNorm;
          end else begin
            state_q <= StPack;
          end
        end
        StNorm: begin
          if (sum_q[24]) begin
            sum_q   <= sum_q >> 1;
            ex_q    <= ex_q + 9'd1;
            state_q <= StPack;
          end else begin
            sum_q <= shl;
            ex_q  <= ex_dec;
            // Exponent exhausted: flush to +0 rather than produce a denormal.
            if (ex_dec == 9'd0) begin
              zero_q  <= 1'b1;
              state_q <= StPack;
            end else if (shl[23]) begin
              state_q <= StPack;
            end
          end
        end
        StPack: begin
          result  <= packed_res;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fpaddsub_iter.sv
// Scoreboard bench for fpaddsub_iter: driver pushes model results and latencies,
// a negedge monitor pops and compares whenever done is seen.
module tb_fpaddsub_iter;

  localparam int unsigned MaxAlign = 26;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_in = 32'h0;
  logic [31:0] b_in = 32'h0;
  logic        busy, done;
  logic [31:0] result;

  fpaddsub_iter #(.MAX_ALIGN(MaxAlign)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc++;

  // Reference: IEEE single add with flush-to-zero, truncating alignment and normalisation.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output logic [31:0] r, output int lat);
    int ea, eb, ma, mb, ex, ey, mx, my, d, sum, msb, lz, n, e;
    logic sa, sb, sx, sy;
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 0 : (int'(a[22:0]) + (1 << 23));
    mb = (eb == 0) ? 0 : (int'(b[22:0]) + (1 << 23));
    if (ea == 255 || eb == 255) begin
      r = 32'h7FC0_0000;
      lat = 2;
      return;
    end
    if (ea > eb || (ea == eb && ma >= mb)) begin
      ex = ea; mx = ma; sx = sa; ey = eb; my = mb; sy = sb;
    end else begin
      ex = eb; mx = mb; sx = sb; ey = ea; my = ma; sy = sa;
    end
    d = ex - ey;
    if (d > int'(MaxAlign)) d = int'(MaxAlign);
    my = my >> d;
    sum = (sx == sy) ? mx + my : mx - my;
    if (sum == 0) begin
      r = 32'h0;
      lat = 3 + d;
      return;
    end
    msb = $clog2(sum + 1) - 1;
    r = 32'h0;
    if (msb == 24) begin
      n = 1;
      e = ex + 1;
      sum = sum >> 1;
    end else begin
      lz = 23 - msb;
      if (lz >= ex) begin
        n = ex;
        e = 0;
      end else begin
        n = lz;
        e = ex - lz;
        sum = sum << lz;
      end
    end
    if (e == 0) r = 32'h0;
    else if (e >= 255) r = {sx, 8'hFF, 23'h0};
    else r = {sx, 8'(e), 23'(sum)};
    lat = 3 + d + n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_done: got result %h with nothing outstanding", result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", result, e.res);
        n_cmp++;
        if (cyc - e.acc != e.lat) begin
          n_err++;
          $display("FAIL latency: got %0d edges expected %0d (result %h)",
                   cyc - e.acc, e.lat, e.res);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int t;
    exp_t e;
    t = 0;
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy, t);
    end
    model(a, b, sub, e.res, e.lat);
    e.acc = cyc + 1;
    sbq.push_back(e);
    start = 1'b1;
    a_in = a;
    b_in = b;
    op = sub;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || sbq.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (busy || sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy %b outstanding %0d, required 0 and 0", busy, sbq.size());
      sbq.delete();
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0:       e = 8'($urandom_range(0, 255));
      1:       e = 8'd0;
      2:       e = 8'($urandom_range(1, 4));
      3:       e = 8'($urandom_range(250, 254));
      default: e = 8'($urandom_range(120, 134));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] ra, rb;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h42C4_0000, 32'h4329_0000, 1'b0);   // 98 + 169
    wait_idle();
    issue(32'h42C6_0000, 32'h42B2_0000, 1'b1);   // 99 - 89
    while (busy) @(negedge clk);
    chk("b2b_in_done_cycle", {31'd0, done}, 32'd1);
    issue(32'hC2DC_4000, 32'h42C7_C000, 1'b0);   // -110.125 + 99.875
    wait_idle();
    issue(32'h0000_0000, 32'h0000_0000, 1'b0);
    issue(32'h42C6_0000, 32'h42C6_0000, 1'b1);
    issue(32'h0000_0000, 32'hC2EA_0000, 1'b0);
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0);
    issue(32'h7F80_0000, 32'h3F80_0000, 1'b0);
    issue(32'h4B80_0000, 32'h3F80_0000, 1'b0);
    wait_idle();

    // Starts while busy must be ignored.
    issue(32'h42C4_0000, 32'h4329_0000, 1'b0);
    start = 1'b1;
    a_in = 32'h3F80_0000;
    b_in = 32'h4000_0000;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ignored_start_result", result, 32'h4385_8000);

    // Asynchronous reset while aligning.
    issue(32'h4B80_0000, 32'h3F80_0000, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", {31'd0, busy}, 32'd0);
    chk("midrun_reset_done", {31'd0, done}, 32'd0);
    chk("midrun_reset_result", result, 32'h0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h42C4_0000, 32'h4329_0000, 1'b0);
    wait_idle();

    for (int i = 0; i < 200; i++) begin
      ra = rnd_fp();
      rb = ($urandom_range(0, 3) == 0) ? (ra ^ ($urandom & 32'h8000_03FF)) : rnd_fp();
      issue(ra, rb, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
